acc_shift_i: RTL and testbench



---
 rtl/acc_shift_pkg.sv | 35 +++
 rtl/acc_shift_i_minor_cycle_counter.sv | 56 +++++
 rtl/acc_shift_i.sv | 138 +++++++++++++
 tb/tb_acc_shift_i.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_shift_pkg.sv
// -----------------------------------------------------------------------------
// acc_shift_pkg
// Shared constants and types for the Accumulator Shift Unit I slice.
//   X_HOLD / X_LEFT / X_RIGHT : gating EMF codes driven to ASU II
//                               (bit 0 = x1, bit 1 = x2, bit 2 = x3, bit 3 = x4)
//   state_t                   : order sequencing states
//   MINOR_CYCLE_DEFAULT       : digit positions per minor cycle (17 + guard)
//   SHIFT_W_DEFAULT           : width of the shift-count field
//   shift_code()              : gating code for a shift direction
// -----------------------------------------------------------------------------
package acc_shift_pkg;

    localparam int MINOR_CYCLE_DEFAULT = 18;
    localparam int SHIFT_W_DEFAULT     = 5;

    // 2-digit path: accumulator recirculates unshifted.
    localparam logic [3:0] X_HOLD  = 4'b1001;
    // 3-digit path: one place left (x2) per minor cycle.
    localparam logic [3:0] X_LEFT  = 4'b1010;
    // 1-digit path: one place right (/2) per minor cycle.
    localparam logic [3:0] X_RIGHT = 4'b0101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        SHIFT  = 2'd2,
        FINISH = 2'd3
    } state_t;

    // dir = 0 : left shift, dir = 1 : right shift
    function automatic logic [3:0] shift_code(input logic dir);
        return dir ? X_RIGHT : X_LEFT;
    endfunction

endpackage

// File: rtl/acc_shift_i_minor_cycle_counter.sv
// -----------------------------------------------------------------------------
// acc_shift_i_minor_cycle_counter
// Tracks the digit position within the minor cycle and keeps it aligned to the
// machine's minor-cycle timing pulse.
// Ports:
//   clk           in   digit clock
//   rst           in   synchronous active-high reset
//   i_minor_start in   timing pulse, high during digit position 0
//   o_boundary    out  high in the cycle whose closing edge is a minor-cycle
//                      boundary (last digit position, or a resync)
//   o_sync_err    out  one-cycle pulse after the timing pulse disagreed with
//                      the internal digit position
// -----------------------------------------------------------------------------
module acc_shift_i_minor_cycle_counter
    import acc_shift_pkg::*;
#(
    parameter int MINOR_CYCLE = MINOR_CYCLE_DEFAULT,
    parameter int DW          = $clog2(MINOR_CYCLE)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_minor_start,
    output logic o_boundary,
    output logic o_sync_err
);

    logic [DW-1:0] r_digit_pos;
    logic          r_sync_err;
    logic          w_last;
    logic          w_resync;

    assign w_last   = (r_digit_pos == DW'(MINOR_CYCLE - 1));
    // The pulse marks digit 0, so the position that follows it is 1.
    assign w_resync = i_minor_start && (r_digit_pos != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_digit_pos <= '0;
            r_sync_err  <= 1'b0;
        end else begin
            r_sync_err <= w_resync;
            if (w_resync) begin
                r_digit_pos <= DW'(1);
            end else if (w_last) begin
                r_digit_pos <= '0;
            end else begin
                r_digit_pos <= r_digit_pos + 1'b1;
            end
        end
    end

    // A resync closes the current (partial) minor cycle just like a wrap does.
    assign o_boundary = w_last || w_resync;
    assign o_sync_err = r_sync_err;

endmodule

// File: rtl/acc_shift_i.sv
// -----------------------------------------------------------------------------
// acc_shift_i  --  Accumulator Shift Unit I
// Accepts a shift order and drives the gating EMFs x[3:0] that route the serial
// accumulator through the 1-, 2- or 3-digit delay path of ASU II, one place per
// minor cycle. x only changes on minor-cycle boundaries so each code is valid
// from digit 0.
// Ports:
//   clk, rst       digit clock, synchronous active-high reset
//   minor_start    timing pulse, high during digit position 0
//   order_valid    shift order present
//   order_ready    order accepted when high together with order_valid (IDLE)
//   order_dir      0 = left (x2 per place), 1 = right (/2 per place)
//   order_count    number of places
//   x              gating code: X_HOLD, X_LEFT or X_RIGHT
//   busy           order in progress
//   done           one-cycle pulse when an order completes
//   sync_err       one-cycle pulse on a timing-pulse disagreement
//   remaining_out  (only with ACC_SHIFT_I_STATUS_EN) minor cycles still to be
//                  shifted including the current one; 0 in IDLE and FINISH
// Build option: define ACC_SHIFT_I_STATUS_EN to add remaining_out.
// -----------------------------------------------------------------------------
module acc_shift_i
    import acc_shift_pkg::*;
#(
    parameter int MINOR_CYCLE = MINOR_CYCLE_DEFAULT,
    parameter int SHIFT_W     = SHIFT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               minor_start,
    input  logic               order_valid,
    output logic               order_ready,
    input  logic               order_dir,
    input  logic [SHIFT_W-1:0] order_count,
    output logic [3:0]         x,
    output logic               busy,
    output logic               done,
`ifdef ACC_SHIFT_I_STATUS_EN
    output logic               sync_err,
    output logic [SHIFT_W-1:0] remaining_out
`else
    output logic               sync_err
`endif
);

    logic               w_boundary;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_dir;
    logic               w_dir_next;
    logic [SHIFT_W-1:0] r_count;
    logic [SHIFT_W-1:0] w_count_next;
    logic [SHIFT_W-1:0] r_remaining;
    logic [SHIFT_W-1:0] w_remaining_next;
    logic [3:0]         r_x;
    logic [3:0]         w_x_next;

    acc_shift_i_minor_cycle_counter #(
        .MINOR_CYCLE (MINOR_CYCLE)
    ) u_mcc (
        .clk           (clk),
        .rst           (rst),
        .i_minor_start (minor_start),
        .o_boundary    (w_boundary),
        .o_sync_err    (sync_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_dir       <= 1'b0;
            r_count     <= '0;
            r_remaining <= '0;
            r_x         <= X_HOLD;
        end else begin
            r_state     <= w_state_next;
            r_dir       <= w_dir_next;
            r_count     <= w_count_next;
            r_remaining <= w_remaining_next;
            r_x         <= w_x_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_dir_next       = r_dir;
        w_count_next     = r_count;
        w_remaining_next = r_remaining;
        w_x_next         = r_x;
        case (r_state)
            IDLE: begin
                if (order_valid) begin
                    w_dir_next   = order_dir;
                    w_count_next = order_count;
                    // A zero-place order completes at once without waiting
                    // for a minor cycle.
                    w_state_next = (order_count == '0) ? FINISH : ARMED;
                end
            end
            ARMED: begin
                // Waiting for a whole minor cycle to start, never a partial one.
                if (w_boundary) begin
                    w_x_next         = shift_code(r_dir);
                    w_remaining_next = r_count;
                    w_state_next     = SHIFT;
                end
            end
            SHIFT: begin
                if (w_boundary) begin
                    if (r_remaining == SHIFT_W'(1)) begin
                        w_x_next         = X_HOLD;
                        w_remaining_next = '0;
                        w_state_next     = FINISH;
                    end else begin
                        w_remaining_next = r_remaining - 1'b1;
                    end
                end
            end
            FINISH: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign x           = r_x;
    assign order_ready = (r_state == IDLE);
    assign busy        = (r_state == ARMED) || (r_state == SHIFT);
    assign done        = (r_state == FINISH);

`ifdef ACC_SHIFT_I_STATUS_EN
    assign remaining_out = r_remaining;
`endif

endmodule

// File: tb/tb_acc_shift_i.sv
// -----------------------------------------------------------------------------
// tb_acc_shift_i
// Self-checking bench for acc_shift_i. Expected timing of each order is derived
// arithmetically from the accept digit, the count and any injected resync.
// -----------------------------------------------------------------------------
module tb_acc_shift_i;
    import acc_shift_pkg::*;

    localparam int MC = 18;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          minor_start;
    logic          order_valid;
    logic          order_ready;
    logic          order_dir;
    logic [SW-1:0] order_count;
    logic [3:0]    x;
    logic          busy;
    logic          done;
    logic          sync_err;
`ifdef ACC_SHIFT_I_STATUS_EN
    logic [SW-1:0] remaining_out;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int tb_digit = 0;

    always #5 clk = ~clk;

    acc_shift_i #(
        .MINOR_CYCLE (MC),
        .SHIFT_W     (SW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .minor_start   (minor_start),
        .order_valid   (order_valid),
        .order_ready   (order_ready),
        .order_dir     (order_dir),
        .order_count   (order_count),
        .x             (x),
        .busy          (busy),
        .done          (done),
`ifdef ACC_SHIFT_I_STATUS_EN
        .sync_err      (sync_err),
        .remaining_out (remaining_out)
`else
        .sync_err      (sync_err)
`endif
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one digit; machine timing pulse follows the bench's digit track.
    task automatic tick();
        @(posedge clk);
        #1;
        tb_digit    = (tb_digit == MC - 1) ? 0 : tb_digit + 1;
        minor_start = (tb_digit == 0);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        minor_start = 1'b0;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        tb_digit    = 0;
        minor_start = 1'b1;
    endtask

    task automatic wait_digit(input int d);
        for (int i = 0; i < MC + 1 && tb_digit != d; i++) tick();
    endtask

    // Issue one order at digit d. With inject, a stray timing pulse is sent at
    // the first digit 7 of the shift (needs cnt >= 2).
    task automatic run_order(input logic dir, input int cnt, input int d,
                             input bit inject, input string name);
        int k, len_exp, first, len, bad_code, done_t, done_n, busy_bad, serr;
        bit injected;
        logic [3:0] code;
`ifdef ACC_SHIFT_I_STATUS_EN
        int rem_first;
        rem_first = -1;
`endif
        wait_digit(d);
        chk({name, "_ready_pre"}, 32'(order_ready), 32'd1);
        order_valid = 1'b1;
        order_dir   = dir;
        order_count = SW'(cnt);
        tick();
        order_valid = 1'b0;
        if (cnt == 0) begin
            chk({name, "_done"}, 32'(done), 32'd1);
            chk({name, "_busy"}, 32'(busy), 32'd0);
            chk({name, "_x"}, 32'(x), 32'(X_HOLD));
            tick();
            chk({name, "_done_end"}, 32'(done), 32'd0);
            chk({name, "_ready_post"}, 32'(order_ready), 32'd1);
            chk({name, "_x_post"}, 32'(x), 32'(X_HOLD));
            $display("order %s dir=%0d count=%0d digit=%0d: immediate done", name, dir, cnt, d);
            return;
        end
        // Shift code appears at the first digit 0 that follows a boundary
        // after the accept edge.
        k = MC - ((d + 1) % MC);
        // A resync at digit 7 shortens its minor cycle to 8 digits and the
        // next one (starting at digit 1) to MC-1 digits.
        len_exp  = inject ? (8 + (MC - 1) + MC * (cnt - 2)) : cnt * MC;
        code     = dir ? X_RIGHT : X_LEFT;
        first    = -1; len = 0; bad_code = 0; done_t = -1; done_n = 0;
        busy_bad = 0; serr = 0; injected = 1'b0;
        for (int t = 0; t <= k + len_exp + 2; t++) begin
            if (x !== X_HOLD) begin
                if (first < 0) first = t;
                len++;
                if (x !== code) bad_code++;
            end
            if (done === 1'b1) begin
                if (done_t < 0) done_t = t;
                done_n++;
            end
            if (sync_err === 1'b1) serr++;
            if (t < k + len_exp && (busy !== 1'b1 || order_ready !== 1'b0)) busy_bad++;
            if (t == k + len_exp && busy !== 1'b0) busy_bad++;
`ifdef ACC_SHIFT_I_STATUS_EN
            if (t == k) rem_first = int'(remaining_out);
`endif
            // Orders offered while busy must be ignored.
            order_valid = (t < k + len_exp) ? 1'($urandom_range(0, 1)) : 1'b0;
            order_dir   = 1'($urandom);
            order_count = SW'($urandom);
            if (inject && !injected && first >= 0 && tb_digit == 7) begin
                injected    = 1'b1;
                minor_start = 1'b1;
                @(posedge clk);
                #1;
                tb_digit    = 1;
                minor_start = 1'b0;
            end else begin
                tick();
            end
        end
        order_valid = 1'b0;
        chk({name, "_start"}, 32'(first), 32'(k));
        chk({name, "_len"}, 32'(len), 32'(len_exp));
        chk({name, "_code"}, 32'(bad_code), 32'd0);
        chk({name, "_done_t"}, 32'(done_t), 32'(k + len_exp));
        chk({name, "_done_n"}, 32'(done_n), 32'd1);
        chk({name, "_busy"}, 32'(busy_bad), 32'd0);
        chk({name, "_sync_err"}, 32'(serr), inject ? 32'd1 : 32'd0);
        chk({name, "_ready_post"}, 32'(order_ready), 32'd1);
`ifdef ACC_SHIFT_I_STATUS_EN
        chk({name, "_remaining"}, 32'(rem_first), 32'(cnt));
`endif
        $display("order %s dir=%0d count=%0d digit=%0d: start=%0d len=%0d done_at=%0d",
                 name, dir, cnt, d, first, len, done_t);
    endtask

    initial begin
        int bad_x, bad_se, bad_rdy, dn, nh;
        rst         = 1'b1;
        minor_start = 1'b0;
        order_valid = 1'b0;
        order_dir   = 1'b0;
        order_count = '0;
        repeat (3) @(posedge clk);
        do_reset();
        chk("rst_x", 32'(x), 32'(X_HOLD));
        chk("rst_ready", 32'(order_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sync_err", 32'(sync_err), 32'd0);
`ifdef ACC_SHIFT_I_STATUS_EN
        chk("rst_remaining", 32'(remaining_out), 32'd0);
`endif

        bad_x = 0; bad_se = 0; bad_rdy = 0;
        for (int i = 0; i < 40; i++) begin
            if (x !== X_HOLD) bad_x++;
            if (sync_err !== 1'b0) bad_se++;
            if (order_ready !== 1'b1) bad_rdy++;
            tick();
        end
        chk("idle_x", 32'(bad_x), 32'd0);
        chk("idle_sync_err", 32'(bad_se), 32'd0);
        chk("idle_ready", 32'(bad_rdy), 32'd0);
        $display("idle 40 cycles: x_bad=%0d sync_err=%0d ready_bad=%0d", bad_x, bad_se, bad_rdy);

        run_order(1'b0, 3, 5, 1'b0, "left3_d5");
        run_order(1'b1, 1, 17, 1'b0, "right1_d17");
        run_order(1'b0, 0, 9, 1'b0, "zero");
        run_order(1'b0, 3, 2, 1'b1, "resync");

        // Reset in the middle of a 5-place order.
        wait_digit(3);
        order_valid = 1'b1;
        order_dir   = 1'b0;
        order_count = SW'(5);
        tick();
        order_valid = 1'b0;
        for (int i = 0; i < 2 * MC && x === X_HOLD; i++) tick();
        chk("midrst_started", 32'(x), 32'(X_LEFT));
        repeat (2 * MC) tick();
        chk("midrst_still_shift", 32'(x), 32'(X_LEFT));
        do_reset();
        chk("midrst_x", 32'(x), 32'(X_HOLD));
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_ready", 32'(order_ready), 32'd1);
        dn = 0; nh = 0;
        for (int i = 0; i < 30; i++) begin
            if (done === 1'b1) dn++;
            if (x !== X_HOLD) nh++;
            tick();
        end
        chk("midrst_no_done", 32'(dn), 32'd0);
        chk("midrst_hold", 32'(nh), 32'd0);
        $display("reset mid-order: done_pulses=%0d non_hold=%0d", dn, nh);
        run_order(1'b1, 2, 11, 1'b0, "after_rst");

        for (int r = 0; r < 8; r++) begin
            run_order(1'($urandom), int'($urandom_range(0, 4)),
                      int'($urandom_range(0, MC - 1)), 1'b0, $sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
